// File: rtl/display_scanner.sv
// Multiplexed 7-segment scanner: snapshots the six BCD digits once per frame
// and drives them onto a shared segment bus with one-hot digit enables.
module display_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b0
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic [3:0] display_s0_export,
  input  logic [3:0] display_s1_export,
  input  logic [3:0] display_m0_export,
  input  logic [3:0] display_m1_export,
  input  logic [3:0] display_h0_export,
  input  logic [3:0] display_h1_export,
  input  logic       alarm_export,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic [5:0] an_o,
  output logic       frame_o
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST    = FW'(BLINK_FRAMES - 1);
  localparam logic [2:0]    SLOT_LAST     = 3'd5;

  logic [PW-1:0] prescaler;
  logic          tick;
  logic [2:0]    slot;

  logic [3:0]    sh_s0, sh_s1, sh_m0, sh_m1, sh_h0, sh_h1;
  logic          sh_alarm;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;

  logic [6:0]    seg_q;
  logic          dp_q;
  logic [5:0]    an_q;
  logic          frame_q;

  logic [3:0]    digit;
  logic [6:0]    decoded;
  logic          dark;
  logic [6:0]    seg_next;
  logic          dp_next;

  assign tick = (prescaler == PRESCALE_LAST);

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      prescaler <= '0;
      slot      <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + PW'(1);
      if (tick) begin
        slot <= (slot == SLOT_LAST) ? 3'd0 : slot + 3'd1;
      end
    end
  end

  always_comb begin
    case (slot)
      3'd0:    digit = sh_s0;
      3'd1:    digit = sh_s1;
      3'd2:    digit = sh_m0;
      3'd3:    digit = sh_m1;
      3'd4:    digit = sh_h0;
      default: digit = sh_h1;
    endcase
    case (digit)
      4'd0:    decoded = 7'h3F;
      4'd1:    decoded = 7'h06;
      4'd2:    decoded = 7'h5B;
      4'd3:    decoded = 7'h4F;
      4'd4:    decoded = 7'h66;
      4'd5:    decoded = 7'h6D;
      4'd6:    decoded = 7'h7D;
      4'd7:    decoded = 7'h07;
      4'd8:    decoded = 7'h7F;
      4'd9:    decoded = 7'h6F;
      default: decoded = 7'h40;
    endcase
    // Blink darkens segments and points alike; the hour-tens blank only hides a leading zero.
    dark     = sh_alarm & blink_phase;
    seg_next = decoded;
    if (dark || (slot == SLOT_LAST && sh_h1 == 4'd0)) begin
      seg_next = 7'h00;
    end
    dp_next = !dark && (slot == 3'd2 || slot == 3'd4);
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      seg_q   <= '0;
      dp_q    <= 1'b0;
      an_q    <= '0;
      frame_q <= 1'b0;
    end else begin
      frame_q <= tick && (slot == SLOT_LAST);
      if (tick) begin
        seg_q <= seg_next;
        dp_q  <= dp_next;
        an_q  <= 6'b000001 << slot;
      end
    end
  end

  // The last slot of a frame is loaded from the old shadow on the same edge the new one is captured.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sh_s0       <= '0;
      sh_s1       <= '0;
      sh_m0       <= '0;
      sh_m1       <= '0;
      sh_h0       <= '0;
      sh_h1       <= '0;
      sh_alarm    <= 1'b0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (tick && slot == SLOT_LAST) begin
      sh_s0    <= display_s0_export;
      sh_s1    <= display_s1_export;
      sh_m0    <= display_m0_export;
      sh_m1    <= display_m1_export;
      sh_h0    <= display_h0_export;
      sh_h1    <= display_h1_export;
      sh_alarm <= alarm_export;
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

  assign seg_o   = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
  assign dp_o    = SEG_ACTIVE_LOW ? ~dp_q  : dp_q;
  assign an_o    = AN_ACTIVE_LOW  ? ~an_q  : an_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner: a frame-level scoreboard predicts every slot,
// and scenario tasks add targeted checks for snapshot, decode, blank and blink.
module tb_display_scanner;

  localparam int SD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = 6 * SD;
  localparam logic [6:0] DEC_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } slot_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst_inv;
  logic [3:0] s0, s1, m0, m1, h0, h1;
  logic       alarm;
  logic [6:0] seg, seg_inv;
  logic       dp, dp_inv;
  logic [5:0] an, an_inv;
  logic       frame, frame_inv;

  slot_t exp_q [$];
  slot_t cur;
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    snaps = 0;

  display_scanner #(.SCAN_DIV(SD), .BLINK_FRAMES(BF), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut (
    .clk_clk(clk), .reset_reset(rst),
    .display_s0_export(s0), .display_s1_export(s1), .display_m0_export(m0),
    .display_m1_export(m1), .display_h0_export(h0), .display_h1_export(h1),
    .alarm_export(alarm), .seg_o(seg), .dp_o(dp), .an_o(an), .frame_o(frame)
  );

  display_scanner #(.SCAN_DIV(SD), .BLINK_FRAMES(BF), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut_inv (
    .clk_clk(clk), .reset_reset(rst_inv),
    .display_s0_export(s0), .display_s1_export(s1), .display_m0_export(m0),
    .display_m1_export(m1), .display_h0_export(h0), .display_h1_export(h1),
    .alarm_export(alarm), .seg_o(seg_inv), .dp_o(dp_inv), .an_o(an_inv), .frame_o(frame_inv)
  );

  always #5 clk = ~clk;

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [3:0] ds0, ds1, dm0, dm1, dh0, dh1, input logic al, input logic ph);
    logic [3:0] dg [6];
    dg[0] = ds0; dg[1] = ds1; dg[2] = dm0; dg[3] = dm1; dg[4] = dh0; dg[5] = dh1;
    for (int i = 0; i < 6; i++) begin
      slot_t e;
      logic  blanked;
      blanked = al && ph;
      e.an  = 6'(1 << i);
      e.seg = (blanked || (i == 5 && dh1 == 4'd0)) ? 7'h00 : DEC_TAB[dg[i]];
      e.dp  = !blanked && (i == 2 || i == 4);
      exp_q.push_back(e);
    end
  endtask

  // Frame j shows what was captured at snapshot j (zeros for j=0) with blink phase (j/BF)%2.
  task automatic model_loop();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        cyc   = 0;
        snaps = 0;
        exp_q.delete();
        push_frame(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      end else begin
        cyc++;
        if (cyc % FRAME == 0) begin
          snaps++;
          push_frame(s0, s1, m0, m1, h0, h1, alarm, ((snaps / BF) % 2) == 1);
        end
      end
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (rst) begin
        cur = '0;
      end else if (cyc > 0 && cyc % SD == 0) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL scoreboard_underflow at cycle %0d", cyc);
        end else begin
          cur = exp_q.pop_front();
        end
      end
      checks++;
      if ({an, seg, dp} !== {cur.an, cur.seg, cur.dp}) begin
        errors++;
        $display("[TB] FAIL scoreboard cycle %0d: an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                 cyc, an, seg, dp, cur.an, cur.seg, cur.dp);
      end
      checks++;
      if (frame !== (!rst && cyc > 0 && cyc % FRAME == 0)) begin
        errors++;
        $display("[TB] FAIL frame_pulse cycle %0d: frame_o=%b", cyc, frame);
      end
    end
  endtask

  task automatic wait_phase(input int ph);
    int n;
    sync();
    n = 1;
    while (cyc % FRAME != ph && n < 2 * FRAME) begin
      sync();
      n++;
    end
    if (cyc % FRAME != ph) begin
      errors++;
      $display("[TB] FAIL wait_phase timeout: phase=%0d wanted=%0d", cyc % FRAME, ph);
    end
  endtask

  task automatic test_reset();
    int pulses;
    rst = 1'b1; rst_inv = 1'b1;
    h1 = 4'd1; h0 = 4'd2; m1 = 4'd3; m0 = 4'd4; s1 = 4'd5; s0 = 4'd6; alarm = 1'b0;
    repeat (3) sync();
    checks++;
    if ({an, seg, dp, frame} !== 15'd0) begin
      errors++;
      $display("[TB] FAIL reset_values: an=%b seg=%h dp=%b frame=%b, expected all zero", an, seg, dp, frame);
    end
    rst = 1'b0;
    pulses = 0;
    repeat (2 * FRAME) begin
      sync();
      if (frame === 1'b1 && cyc <= FRAME) pulses++;
      if (cyc == 3) begin
        checks++;
        if (an !== 6'b000000) begin
          errors++; $display("[TB] FAIL early_tick: an=%b, expected 000000", an);
        end
      end
      if (cyc == 4) begin
        checks++;
        if (an !== 6'b000001 || seg !== 7'h3F) begin
          errors++; $display("[TB] FAIL first_tick: an=%b seg=%h, expected 000001 3f", an, seg);
        end
      end
      if (cyc == FRAME) begin
        checks++;
        if (an !== 6'b100000 || seg !== 7'h00) begin
          errors++; $display("[TB] FAIL first_frame_blank: an=%b seg=%h, expected 100000 00", an, seg);
        end
      end
      if (cyc == FRAME + 4) begin
        checks++;
        if (seg !== 7'h7D) begin
          errors++; $display("[TB] FAIL second_frame_s0: seg=%h, expected 7d", seg);
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("[TB] FAIL frame_pulse_count: got %0d, expected 1", pulses);
    end
  endtask

  task automatic test_coherence();
    wait_phase(2);
    s0 = 4'd7;
    wait_phase(4);
    checks++;
    if (an !== 6'b000001 || seg !== 7'h7D) begin
      errors++; $display("[TB] FAIL coherence_old: an=%b seg=%h, expected 000001 7d", an, seg);
    end
    wait_phase(4);
    checks++;
    if (an !== 6'b000001 || seg !== 7'h07) begin
      errors++; $display("[TB] FAIL coherence_new: an=%b seg=%h, expected 000001 07", an, seg);
    end
  endtask

  task automatic test_decode_sweep();
    for (int v = 0; v < 16; v++) begin
      wait_phase(12);
      s0 = 4'(v);
      repeat (16) begin
        sync();
        checks++;
        if (dp !== (an == 6'b000100 || an == 6'b010000)) begin
          errors++; $display("[TB] FAIL dp_slots: an=%b dp=%b", an, dp);
        end
      end
      checks++;
      if (an !== 6'b000001 || seg !== DEC_TAB[v]) begin
        errors++; $display("[TB] FAIL decode_%0d: an=%b seg=%h, expected 000001 %h", v, an, seg, DEC_TAB[v]);
      end
    end
  endtask

  task automatic test_leading_blank();
    wait_phase(12);
    s0 = 4'd6; h1 = 4'd0;
    wait_phase(0);
    checks++;
    if (an !== 6'b100000 || seg !== 7'h06) begin
      errors++; $display("[TB] FAIL h1_one: an=%b seg=%h, expected 100000 06", an, seg);
    end
    wait_phase(0);
    checks++;
    if (an !== 6'b100000 || seg !== 7'h00) begin
      errors++; $display("[TB] FAIL h1_blank: an=%b seg=%h, expected 100000 00", an, seg);
    end
    wait_phase(12);
    h1 = 4'd1;
    wait_phase(0);
    wait_phase(0);
    checks++;
    if (an !== 6'b100000 || seg !== 7'h06) begin
      errors++; $display("[TB] FAIL h1_restore: an=%b seg=%h, expected 100000 06", an, seg);
    end
  endtask

  task automatic test_alarm_blink();
    int  dark_frames;
    logic is_dark;
    wait_phase(12);
    alarm = 1'b1;
    dark_frames = 0;
    for (int f = 0; f < 8; f++) begin
      wait_phase(4);
      is_dark = ((snaps / BF) % 2) == 1;
      if (is_dark) dark_frames++;
      checks++;
      if (an !== 6'b000001 || seg !== (is_dark ? 7'h00 : 7'h7D)) begin
        errors++; $display("[TB] FAIL blink_slot0 frame %0d: an=%b seg=%h dark=%b", f, an, seg, is_dark);
      end
      wait_phase(12);
      checks++;
      if (an !== 6'b000100 || dp !== !is_dark || seg !== (is_dark ? 7'h00 : 7'h66)) begin
        errors++; $display("[TB] FAIL blink_slot2 frame %0d: an=%b seg=%h dp=%b dark=%b", f, an, seg, dp, is_dark);
      end
    end
    checks++;
    if (dark_frames != 4) begin
      errors++; $display("[TB] FAIL blink_dark_count: got %0d, expected 4", dark_frames);
    end
    alarm = 1'b0;
    wait_phase(4);
    wait_phase(12);
    checks++;
    if (an !== 6'b000100 || dp !== 1'b1 || seg !== 7'h66) begin
      errors++; $display("[TB] FAIL alarm_off: an=%b seg=%h dp=%b, expected 000100 66 1", an, seg, dp);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    n = 0;
    while (an !== 6'b001000 && n < 2 * FRAME) begin sync(); n++; end
    rst = 1'b1;
    #1;
    checks++;
    if (n >= 2 * FRAME || {an, seg, dp, frame} !== 15'd0) begin
      errors++; $display("[TB] FAIL mid_reset: an=%b seg=%h dp=%b frame=%b, expected zero", an, seg, dp, frame);
    end
    sync(); sync();
    rst = 1'b0;
    repeat (3) sync();
    checks++;
    if (an !== 6'b000000) begin
      errors++; $display("[TB] FAIL mid_reset_hold: an=%b, expected 000000", an);
    end
    sync();
    checks++;
    if (an !== 6'b000001 || seg !== 7'h3F) begin
      errors++; $display("[TB] FAIL mid_reset_restart: an=%b seg=%h, expected 000001 3f", an, seg);
    end

    checks++;
    if (seg_inv !== 7'h7F || dp_inv !== 1'b1 || an_inv !== 6'b111111 || frame_inv !== 1'b0) begin
      errors++; $display("[TB] FAIL inv_reset: an=%b seg=%h dp=%b frame=%b, expected 111111 7f 1 0",
                         an_inv, seg_inv, dp_inv, frame_inv);
    end
    rst_inv = 1'b0;
    repeat (4) sync();
    checks++;
    if (an_inv !== 6'b111110 || seg_inv !== 7'h40 || dp_inv !== 1'b1) begin
      errors++; $display("[TB] FAIL inv_first_tick: an=%b seg=%h dp=%b, expected 111110 40 1", an_inv, seg_inv, dp_inv);
    end
    n = 0;
    while (an_inv !== 6'b110111 && n < 2 * FRAME) begin sync(); n++; end
    rst_inv = 1'b1;
    #1;
    checks++;
    if (n >= 2 * FRAME || seg_inv !== 7'h7F || dp_inv !== 1'b1 || an_inv !== 6'b111111) begin
      errors++; $display("[TB] FAIL inv_mid_reset: an=%b seg=%h dp=%b, expected 111111 7f 1", an_inv, seg_inv, dp_inv);
    end
    sync();
    rst_inv = 1'b0;
    repeat (4) sync();
    checks++;
    if (an_inv !== 6'b111110 || seg_inv !== 7'h40) begin
      errors++; $display("[TB] FAIL inv_restart: an=%b seg=%h, expected 111110 40", an_inv, seg_inv);
    end
  endtask

  initial begin
    rst = 1'b1;
    rst_inv = 1'b1;
    fork
      model_loop();
      monitor_loop();
    join_none
    test_reset();
    test_coherence();
    test_decode_sweep();
    test_leading_blank();
    test_alarm_blink();
    test_reset_mid_frame();
    sync();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
